// File: rtl/present_key_schedule_if.sv
// Handshake bundle between the PRESENT-80 key schedule and whoever loads keys / consumes round keys.
interface present_key_schedule_if;
  logic        load;
  logic [79:0] key_in;
  logic        rk_ready;
  logic [63:0] round_key;
  logic        rk_valid;
  logic [5:0]  round_idx;
  logic        busy;
  logic        done;

  modport master (
    output load, key_in, rk_ready,
    input  round_key, rk_valid, round_idx, busy, done
  );

  modport slave (
    input  load, key_in, rk_ready,
    output round_key, rk_valid, round_idx, busy, done
  );
endinterface

// File: rtl/present_key_schedule.sv
// Sequential PRESENT-80 key schedule: loads an 80-bit key and hands out RK1..RK(ROUNDS)
// one per valid/ready transfer, applying the key-layer S-box on each register update.
module present_key_sbox (
  input  logic [3:0] din,
  output logic [3:0] dout
);
  always_comb begin
    case (din)
      4'h0: dout = 4'hC;
      4'h1: dout = 4'h5;
      4'h2: dout = 4'h6;
      4'h3: dout = 4'hB;
      4'h4: dout = 4'h9;
      4'h5: dout = 4'h0;
      4'h6: dout = 4'hA;
      4'h7: dout = 4'hD;
      4'h8: dout = 4'h3;
      4'h9: dout = 4'hE;
      4'hA: dout = 4'hF;
      4'hB: dout = 4'h8;
      4'hC: dout = 4'h4;
      4'hD: dout = 4'h7;
      4'hE: dout = 4'h1;
      default: dout = 4'h2;
    endcase
  end
endmodule

module present_key_schedule #(
  parameter int ROUNDS = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  present_key_schedule_if.slave  ks
);
  localparam logic [5:0] LAST_IDX = 6'(ROUNDS);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t      state_q, state_d;
  logic [79:0] key_q, key_d;
  logic [5:0]  idx_q, idx_d;
  logic        done_q, done_d;

  logic [79:0] rot;
  logic [3:0]  sbox_out;
  logic [79:0] key_next;

  // Rotate left by 61, substitute the top nibble, then fold the consumed index into bits 19:15.
  assign rot = {key_q[18:0], key_q[79:19]};

  present_key_sbox u_sbox (
    .din  (rot[79:76]),
    .dout (sbox_out)
  );

  assign key_next = {sbox_out, rot[75:20], rot[19:15] ^ idx_q[4:0], rot[14:0]};

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (ks.load) begin
          key_d   = ks.key_in;
          idx_d   = 6'd1;
          state_d = ACTIVE;
        end
      end
      default: begin
        if (ks.rk_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            idx_d   = 6'd0;
            done_d  = 1'b1;
          end else begin
            key_d = key_next;
            idx_d = idx_q + 6'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      key_q   <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  assign ks.round_key = key_q[79:16];
  assign ks.rk_valid  = (state_q == ACTIVE);
  assign ks.busy      = (state_q == ACTIVE);
  assign ks.round_idx = idx_q;
  assign ks.done      = done_q;
endmodule

// File: tb/tb_present_key_schedule.sv
// Randomised bench for present_key_schedule: a ROUNDS=32 and a ROUNDS=4 instance checked against a
// behavioural PRESENT-80 key-schedule model, plus a full encryption of plaintext 0 with the emitted keys.
module tb_present_key_schedule;
  localparam logic [63:0] SBOX_HEX = 64'h21748FE3DA09B65C;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_r = 1'b0;
  logic [79:0] key_r = '0;
  logic        rdy_r = 1'b0;
  bit          sel = 1'b0;
  int          n_chk = 0;
  int          n_fail = 0;
  int          rounds = 32;
  logic [63:0] rk_exp [1:32];
  logic [63:0] got    [1:32];

  always #5 clk = ~clk;

  present_key_schedule_if bus32 ();
  present_key_schedule_if bus4 ();

  assign bus32.load = load_r;  assign bus32.key_in = key_r;  assign bus32.rk_ready = rdy_r;
  assign bus4.load  = load_r;  assign bus4.key_in  = key_r;  assign bus4.rk_ready  = rdy_r;

  present_key_schedule #(.ROUNDS(32)) dut32 (.clk(clk), .rst_n(rst_n), .ks(bus32));
  present_key_schedule #(.ROUNDS(4))  dut4  (.clk(clk), .rst_n(rst_n), .ks(bus4));

  wire [63:0] round_key = sel ? bus4.round_key : bus32.round_key;
  wire        rk_valid  = sel ? bus4.rk_valid  : bus32.rk_valid;
  wire [5:0]  round_idx = sel ? bus4.round_idx : bus32.round_idx;
  wire        busy      = sel ? bus4.busy      : bus32.busy;
  wire        done      = sel ? bus4.done      : bus32.done;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] sbox(input logic [3:0] n);
    logic [63:0] tab;
    tab = SBOX_HEX >> (4 * int'(n));
    return tab[3:0];
  endfunction

  function automatic logic [79:0] ks_update(input logic [79:0] k, input int i);
    logic [79:0] t;
    t = (k << 61) | (k >> 19);
    t[79:76] = sbox(t[79:76]);
    t = t ^ (80'(i % 32) << 15);
    return t;
  endfunction

  task automatic build_schedule(input logic [79:0] key);
    logic [79:0] k;
    k = key;
    rk_exp[1] = k[79:16];
    for (int j = 1; j < rounds; j++) begin
      k = ks_update(k, j);
      rk_exp[j+1] = k[79:16];
    end
  endtask

  function automatic logic [63:0] encrypt0();
    logic [63:0] s, ns;
    s = '0;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ got[r];
      for (int n = 0; n < 16; n++) s[4*n +: 4] = sbox(s[4*n +: 4]);
      ns = '0;
      for (int b = 0; b < 63; b++) ns[(16 * b) % 63] = s[b];
      ns[63] = s[63];
      s = ns;
    end
    return s ^ got[32];
  endfunction

  function automatic logic [79:0] rand_key();
    logic [95:0] w;
    w = {$urandom(), $urandom(), $urandom()};
    return w[79:0];
  endfunction

  task automatic do_load(input logic [79:0] key);
    load_r = 1'b1;
    key_r  = key;
    @(posedge clk);
    @(negedge clk);
    load_r = 1'b0;
    build_schedule(key);
  endtask

  // Called at a negedge with the DUT showing key 'start'; walks to done (or aborts with a reset).
  task automatic run(input int start, input int abort_at, input bit rand_ready, input bit rand_load);
    int pos;
    int cyc;
    pos = start;
    cyc = 0;
    while (pos <= rounds && cyc < 500) begin
      chk("rk_valid", 80'(rk_valid), 80'(1));
      chk("busy", 80'(busy), 80'(1));
      chk("done_low", 80'(done), 80'(0));
      chk("round_idx", 80'(round_idx), 80'(pos));
      chk("round_key", 80'(round_key), 80'(rk_exp[pos]));
      if (pos == abort_at) begin
        rdy_r = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 80'(rk_valid), 80'(0));
        chk("arst_busy", 80'(busy), 80'(0));
        chk("arst_idx", 80'(round_idx), 80'(0));
        chk("arst_key", 80'(round_key), 80'(0));
        chk("arst_done", 80'(done), 80'(0));
        return;
      end
      rdy_r  = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      load_r = rand_load ? 1'($urandom_range(0, 1)) : 1'b0;
      key_r  = rand_key();
      if (pos == 10 && !rand_load) begin
        load_r = 1'b1;
        key_r  = '1;
      end
      if (pos == rounds && rdy_r) load_r = 1'b1;
      if (rdy_r) got[pos] = round_key;
      @(posedge clk);
      if (rdy_r) pos++;
      @(negedge clk);
      cyc++;
    end
    rdy_r  = 1'b0;
    load_r = 1'b0;
    chk("in_budget", 80'(cyc < 500), 80'(1));
    chk("done_pulse", 80'(done), 80'(1));
    chk("end_busy", 80'(busy), 80'(0));
    chk("end_valid", 80'(rk_valid), 80'(0));
    chk("end_idx", 80'(round_idx), 80'(0));
    @(negedge clk);
    chk("done_clear", 80'(done), 80'(0));
    chk("idle_busy", 80'(busy), 80'(0));
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    chk("rst_valid", 80'(rk_valid), 80'(0));
    chk("rst_busy", 80'(busy), 80'(0));
    chk("rst_done", 80'(done), 80'(0));
    chk("rst_idx", 80'(round_idx), 80'(0));
    chk("rst_key", 80'(round_key), 80'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Zero key: first keys, backpressure at index 2, then a full run with a load injected at index 10
    do_load('0);
    chk("rk1_zero", 80'(round_key), 80'(64'h0));
    chk("idx1", 80'(round_idx), 80'(1));
    got[1] = round_key;
    rdy_r = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rdy_r = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk("bp_key", 80'(round_key), 80'(64'hC000000000000000));
      chk("bp_valid", 80'(rk_valid), 80'(1));
      chk("bp_idx", 80'(round_idx), 80'(2));
      @(negedge clk);
    end
    got[2] = round_key;
    rdy_r = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rk3_zero", 80'(round_key), 80'(64'h5000180000000001));
    run(3, 0, 1'b0, 1'b0);
    chk("encrypt0", 80'(encrypt0()), 80'(64'h5579C1387B228445));

    // Reload with all-ones key
    do_load('1);
    chk("rk1_ones", 80'(round_key), 80'(64'hFFFFFFFFFFFFFFFF));
    rdy_r = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rk2_nibble", 80'(round_key[63:60]), 80'(4'h2));
    run(2, 0, 1'b1, 1'b1);

    // Random keys under random backpressure and spurious loads
    for (int t = 0; t < 3; t++) begin
      do_load(rand_key());
      run(1, 0, 1'b1, 1'b1);
    end

    // Asynchronous reset mid-schedule, then a clean reload
    do_load(rand_key());
    run(1, 7, 1'b0, 1'b0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("arst_hold_done", 80'(done), 80'(0));
      chk("arst_hold_busy", 80'(busy), 80'(0));
    end
    rst_n = 1'b1;
    @(negedge clk);
    do_load(rand_key());
    run(1, 0, 1'b1, 1'b0);

    // ROUNDS=4 instance
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sel = 1'b1;
    rounds = 4;
    @(negedge clk);
    chk("r4_idle_busy", 80'(busy), 80'(0));
    for (int t = 0; t < 2; t++) begin
      do_load(rand_key());
      run(1, 0, 1'b1, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
